// File: rtl/hermes_local_injector.sv
// Packetizer feeding a Hermes router LOCAL port: header, size, then payload, under the router's credit flow control.
// Define HERMES_INJ_TIMESTAMP_EN to insert a cycle-count stamp flit after the size flit.
module hermes_local_injector #(
   parameter int FLIT_SIZE     = 32,
   parameter int SIZE_WIDTH    = 16,
   parameter int PKT_CNT_WIDTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   input  logic [15:0]              cmd_target_i,
   input  logic [SIZE_WIDTH-1:0]    cmd_size_i,
   input  logic                     pl_valid_i,
   output logic                     pl_ready_o,
   input  logic [FLIT_SIZE-1:0]     pl_data_i,
   output logic                     tx_o,
   input  logic                     credit_i,
   output logic [FLIT_SIZE-1:0]     data_o,
   output logic                     busy_o,
   output logic [PKT_CNT_WIDTH-1:0] pkt_sent_o
);

   // state     | meaning
   // S_IDLE    | waiting for a command
   // S_HEADER  | loading the header flit
   // S_SIZE    | loading the size flit
   // S_STAMP   | loading the timestamp flit (timestamp build only)
   // S_PAYLOAD | forwarding payload flits
   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_SIZE,
      S_STAMP,
      S_PAYLOAD
   } state_t;

   state_t                   state_q;
   logic [15:0]              target_q;
   logic [SIZE_WIDTH-1:0]    size_q;
   logic [SIZE_WIDTH-1:0]    remaining_q;
   logic                     out_valid_q;
   logic                     out_last_q;
   logic [FLIT_SIZE-1:0]     out_data_q;
   logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q;
   logic                     can_load;

`ifdef HERMES_INJ_TIMESTAMP_EN
   logic [31:0]           cycle_cnt_q;
   logic [31:0]           stamp_q;
   logic [SIZE_WIDTH:0]   size_plus1;

   // Extra bit so a maximum-length packet still reports its stamp flit.
   assign size_plus1 = {1'b0, size_q} + {{SIZE_WIDTH{1'b0}}, 1'b1};
`endif

   assign can_load    = !out_valid_q || credit_i;
   assign cmd_ready_o = (state_q == S_IDLE);
   assign pl_ready_o  = (state_q == S_PAYLOAD) && can_load;
   assign tx_o        = out_valid_q;
   assign data_o      = out_data_q;
   assign busy_o      = (state_q != S_IDLE) || out_valid_q;
   assign pkt_sent_o  = pkt_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         target_q    <= '0;
         size_q      <= '0;
         remaining_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         pkt_cnt_q   <= '0;
`ifdef HERMES_INJ_TIMESTAMP_EN
         cycle_cnt_q <= '0;
         stamp_q     <= '0;
`endif
      end else begin
`ifdef HERMES_INJ_TIMESTAMP_EN
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
`endif
         if (out_valid_q && credit_i && out_last_q) begin
            pkt_cnt_q <= pkt_cnt_q + PKT_CNT_WIDTH'(1);
         end
         // Held flit leaves (or slot was empty); a load below re-arms it.
         if (can_load) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  target_q    <= cmd_target_i;
                  size_q      <= cmd_size_i;
                  remaining_q <= cmd_size_i;
`ifdef HERMES_INJ_TIMESTAMP_EN
                  stamp_q     <= cycle_cnt_q;
`endif
                  state_q     <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (can_load) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= FLIT_SIZE'(target_q);
                  out_last_q  <= 1'b0;
                  state_q     <= S_SIZE;
               end
            end
            S_SIZE: begin
               if (can_load) begin
                  out_valid_q <= 1'b1;
`ifdef HERMES_INJ_TIMESTAMP_EN
                  out_data_q  <= FLIT_SIZE'(size_plus1);
                  out_last_q  <= 1'b0;
                  state_q     <= S_STAMP;
`else
                  out_data_q  <= FLIT_SIZE'(size_q);
                  out_last_q  <= (size_q == '0);
                  state_q     <= (size_q == '0) ? S_IDLE : S_PAYLOAD;
`endif
               end
            end
`ifdef HERMES_INJ_TIMESTAMP_EN
            S_STAMP: begin
               if (can_load) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= FLIT_SIZE'(stamp_q);
                  out_last_q  <= (size_q == '0);
                  state_q     <= (size_q == '0) ? S_IDLE : S_PAYLOAD;
               end
            end
`endif
            S_PAYLOAD: begin
               if (pl_valid_i && can_load) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= pl_data_i;
                  out_last_q  <= (remaining_q == SIZE_WIDTH'(1));
                  remaining_q <= remaining_q - SIZE_WIDTH'(1);
                  if (remaining_q == SIZE_WIDTH'(1)) begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hermes_local_injector.sv
// Bench for hermes_local_injector: directed timing sequences, a vector table and randomized traffic
// checked against a packet-level flit-stream model.
module tb_hermes_local_injector;

   localparam int FW = 32;
   localparam int SW = 16;
   localparam int PW = 16;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [15:0]   cmd_target_i;
   logic [SW-1:0] cmd_size_i;
   logic          pl_valid_i;
   logic          pl_ready_o;
   logic [FW-1:0] pl_data_i;
   logic          tx_o;
   logic          credit_i;
   logic [FW-1:0] data_o;
   logic          busy_o;
   logic [PW-1:0] pkt_sent_o;

   always #5 clk = ~clk;

   hermes_local_injector #(.FLIT_SIZE(FW), .SIZE_WIDTH(SW), .PKT_CNT_WIDTH(PW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_target_i(cmd_target_i), .cmd_size_i(cmd_size_i),
      .pl_valid_i(pl_valid_i), .pl_ready_o(pl_ready_o), .pl_data_i(pl_data_i),
      .tx_o(tx_o), .credit_i(credit_i), .data_o(data_o),
      .busy_o(busy_o), .pkt_sent_o(pkt_sent_o)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each command expands into its full flit list {last, data}.
   logic [15:0] cmdt_q[$];
   logic [15:0] cmds_q[$];
   logic [31:0] pl_q[$];
   logic [32:0] exp_q[$];
   int          model_pkts = 0;

   task automatic add_pkt(input logic [15:0] tgt, input int size);
      logic [31:0] p;
      cmdt_q.push_back(tgt);
      cmds_q.push_back(16'(size));
      exp_q.push_back({1'b0, 32'(tgt)});
      exp_q.push_back({(size == 0), 32'(size)});
      for (int i = 0; i < size; i++) begin
         p = $urandom;
         pl_q.push_back(p);
         exp_q.push_back({(i == size - 1), p});
      end
   endtask

   task automatic run_engine(input int credit_pct, input int pl_pct, input int cmd_pct, input int budget,
                             output int nflits, output logic [31:0] first_flit);
      int          cyc = 0;
      bit          held = 0;
      logic [31:0] held_data = '0;
      logic [32:0] e;
      nflits = 0;
      first_flit = '0;
      while ((cmdt_q.size() != 0 || exp_q.size() != 0 || busy_o) && cyc < budget) begin
         @(negedge clk);
         check("pkt_sent", pkt_sent_o, model_pkts);
         credit_i    = ($urandom_range(99) < credit_pct);
         pl_valid_i  = (pl_q.size() != 0) && ($urandom_range(99) < pl_pct);
         pl_data_i   = pl_valid_i ? pl_q[0] : $urandom;
         cmd_valid_i = (cmdt_q.size() != 0) && ($urandom_range(99) < cmd_pct);
         cmd_target_i = cmd_valid_i ? cmdt_q[0] : 16'($urandom);
         cmd_size_i   = cmd_valid_i ? cmds_q[0] : 16'($urandom);
         #1;
         if (held) check("hold_stable", {tx_o, data_o}, {1'b1, held_data});
         if (cmd_valid_i && cmd_ready_o) begin
            void'(cmdt_q.pop_front());
            void'(cmds_q.pop_front());
         end
         if (pl_valid_i && pl_ready_o) void'(pl_q.pop_front());
         if (tx_o && credit_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL extra_flit: got 0x%0h, expected no flit at %0t", data_o, $time);
            end else begin
               e = exp_q.pop_front();
               check("flit", data_o, e[31:0]);
               if (e[32]) model_pkts++;
               nflits++;
               if (nflits == 1) first_flit = data_o;
            end
         end
         held      = tx_o && !credit_i;
         held_data = data_o;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= budget) begin
         n_checks++;
         $display("FAIL engine_timeout: got %0d flits pending, expected 0", exp_q.size());
         cmdt_q.delete(); cmds_q.delete(); pl_q.delete(); exp_q.delete();
      end
      cmd_valid_i = 1'b0;
      pl_valid_i  = 1'b0;
      check("pkt_sent_end", pkt_sent_o, model_pkts);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1; cmd_valid_i = 1'b0; pl_valid_i = 1'b0; credit_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      check("rst_tx", tx_o, 0);
      check("rst_data", data_o, 0);
      check("rst_cmd_ready", cmd_ready_o, 1);
      check("rst_pl_ready", pl_ready_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_pkt", pkt_sent_o, 0);
      model_pkts = 0;
   endtask

   task automatic accept(input logic [15:0] tgt, input logic [15:0] size);
      @(negedge clk);
      cmd_valid_i = 1'b1; cmd_target_i = tgt; cmd_size_i = size;
      #1;
      check("cmd_ready_idle", cmd_ready_o, 1);
      @(posedge clk);
   endtask

   // Packet 0x0102/size 3; credit withheld for 'stall' cycles once the header is visible.
   task automatic fixed_seq(input int stall);
      logic [31:0] e[5];
      logic [31:0] pays[3];
      int idx = 0;
      e = '{32'h102, 32'h3, 32'hA, 32'hB, 32'hC};
      pays = '{32'hA, 32'hB, 32'hC};
      do_reset();
      accept(16'h0102, 16'd3);
      for (int k = 0; k <= 6 + stall; k++) begin
         @(negedge clk);
         cmd_valid_i = 1'b0;
         credit_i = !(k >= 1 && k <= stall);
         pl_valid_i = (idx < 3);
         if (idx < 3) pl_data_i = pays[idx];
         #1;
         if (k == 0) check("seq_hdr_wait", tx_o, 0);
         else if (k <= 1 + stall) check("seq_hdr", {tx_o, data_o}, {1'b1, e[0]});
         else if (k <= 5 + stall) check("seq_flit", {tx_o, data_o}, {1'b1, e[k - 1 - stall]});
         else begin
            check("seq_end_tx", tx_o, 0);
            check("seq_end_busy", busy_o, 0);
            check("seq_end_pkt", pkt_sent_o, 1);
         end
         if (k == 5 + stall) begin
            check("seq_busy_last", busy_o, 1);
            check("seq_pkt_before", pkt_sent_o, 0);
         end
         if (k >= 1 && k <= stall) check("seq_stall_plready", pl_ready_o, 0);
         if (pl_valid_i && pl_ready_o) idx++;
      end
      pl_valid_i = 1'b0;
   endtask

   typedef struct {
      logic [15:0] tgt;
      int          size;
      int          credit_pct;
      int          pl_pct;
      int          exp_nflits;
      logic [31:0] exp_hdr;
   } vec_t;

   vec_t        vecs[6];
   int          nf;
   logic [31:0] ff;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] pays4[2];
      int idx;
      rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_target_i = '0; cmd_size_i = '0;
      pl_valid_i = 1'b0; pl_data_i = '0; credit_i = 1'b1;

      vecs[0] = '{16'h0102, 3, 100, 100, 5, 32'h0000_0102};
      vecs[1] = '{16'hFFFF, 0, 100, 100, 2, 32'h0000_FFFF};
      vecs[2] = '{16'h0A05, 1,  50, 100, 3, 32'h0000_0A05};
      vecs[3] = '{16'h0300, 7,  60,  40, 9, 32'h0000_0300};
      vecs[4] = '{16'h8001, 4,  30,  80, 6, 32'h0000_8001};
      vecs[5] = '{16'h00FF, 2, 100,  30, 4, 32'h0000_00FF};

      fixed_seq(0);
      fixed_seq(4);

      // Zero-length packet: header and size flits only.
      do_reset();
      pl_valid_i = 1'b1; pl_data_i = 32'hDEAD_BEEF;
      accept(16'h0000, 16'd0);
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         cmd_valid_i = 1'b0;
         #1;
         if (k == 0) check("z_hdr_wait", tx_o, 0);
         if (k == 1) check("z_hdr", {tx_o, data_o}, {1'b1, 32'h0});
         if (k == 2) begin
            check("z_size", {tx_o, data_o}, {1'b1, 32'h0});
            check("z_cmd_ready", cmd_ready_o, 1);
         end
         if (k == 3) begin
            check("z_end_tx", tx_o, 0);
            check("z_pkt", pkt_sent_o, 1);
         end
         check("z_no_payload", pl_ready_o, 0);
      end
      pl_valid_i = 1'b0;

      // Payload bubbles: pl_valid toggling 1,0,1,0 on a size-2 packet.
      do_reset();
      pays4 = '{32'h11, 32'h22};
      idx = 0;
      accept(16'h0203, 16'd2);
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         cmd_valid_i = 1'b0;
         pl_valid_i = (k % 2 == 0) && (idx < 2);
         if (idx < 2) pl_data_i = pays4[idx];
         #1;
         if (k == 3) check("b_flit1", {tx_o, data_o}, {1'b1, 32'h11});
         if (k == 4) check("b_gap", tx_o, 0);
         if (k == 5) begin
            check("b_flit2", {tx_o, data_o}, {1'b1, 32'h22});
            check("b_pkt_before", pkt_sent_o, 0);
         end
         if (k == 6) begin
            check("b_end_tx", tx_o, 0);
            check("b_pkt", pkt_sent_o, 1);
         end
         if (pl_valid_i && pl_ready_o) idx++;
      end
      pl_valid_i = 1'b0;

      // Reset right after the header of a size-5 packet.
      accept(16'h0405, 16'd5);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      @(negedge clk);
      #1;
      check("r_hdr", {tx_o, data_o}, {1'b1, 32'h405});
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      check("r_tx", tx_o, 0);
      check("r_cmd_ready", cmd_ready_o, 1);
      check("r_pkt", pkt_sent_o, 0);
      check("r_busy", busy_o, 0);
      model_pkts = 0;
      add_pkt(16'h0506, 2);
      run_engine(100, 100, 100, 200, nf, ff);
      check("r_after_nflits", nf, 4);

      for (int v = 0; v < 6; v++) begin
         add_pkt(vecs[v].tgt, vecs[v].size);
         run_engine(vecs[v].credit_pct, vecs[v].pl_pct, 100, 500, nf, ff);
         check("vec_nflits", nf, vecs[v].exp_nflits);
         check("vec_hdr", ff, vecs[v].exp_hdr);
      end

      for (int p = 0; p < 40; p++) add_pkt(16'($urandom), $urandom_range(0, 6));
      run_engine(70, 70, 60, 5000, nf, ff);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
